// File: rtl/fp_div_issue.sv
// Two-entry issue FIFO in front of an FP divider: classifies operand pairs and flushes denormals at push.
// Optional macro FP_DIV_ISSUE_STATS_EN adds a saturating divide-by-zero pop counter (div0_cnt).
module fp_div_issue #(
  parameter int m = 8,
  parameter int n = 23
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [m+n:0]   a_in,
  input  logic [m+n:0]   b_in,
  input  logic [1:0]     o,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [m+n:0]   a_out,
  output logic [m+n:0]   b_out,
  output logic [1:0]     o_out,
  output logic [2:0]     cls
`ifdef FP_DIV_ISSUE_STATS_EN
  ,
  output logic [15:0]    div0_cnt
`endif
);

  function automatic logic exp_ones(input logic [m+n:0] x);
    return &x[m+n-1:n];
  endfunction

  function automatic logic exp_zero(input logic [m+n:0] x);
    return ~|x[m+n-1:n];
  endfunction

  function automatic logic is_nan(input logic [m+n:0] x);
    return exp_ones(x) && (|x[n-1:0]);
  endfunction

  function automatic logic is_inf(input logic [m+n:0] x);
    return exp_ones(x) && !(|x[n-1:0]);
  endfunction

  // Zero and denormal both collapse to a signed zero.
  function automatic logic [m+n:0] ftz(input logic [m+n:0] x);
    return exp_zero(x) ? {x[m+n], {(m+n){1'b0}}} : x;
  endfunction

  function automatic logic [2:0] classify(input logic [m+n:0] a, input logic [m+n:0] b);
    if (is_nan(a) || is_nan(b))      return 3'd4;
    else if (is_inf(a) || is_inf(b)) return 3'd3;
    else if (exp_zero(b))            return 3'd2;
    else if (exp_zero(a))            return 3'd1;
    else                             return 3'd0;
  endfunction

  logic [1:0]   cnt_q, cnt_d;
  logic         in_ready_q, out_valid_q;
  logic [m+n:0] ha_q, ha_d, hb_q, hb_d, ta_q, ta_d, tb_q, tb_d;
  logic [1:0]   ho_q, ho_d, to_q, to_d;
  logic [2:0]   hc_q, hc_d, tc_q, tc_d;
  logic [m+n:0] na, nb;
  logic [2:0]   nc;
  logic         push, pop;

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid_q && out_ready;
  assign na   = ftz(a_in);
  assign nb   = ftz(b_in);
  assign nc   = classify(a_in, b_in);

  always_comb begin
    cnt_d = cnt_q;
    ha_d = ha_q; hb_d = hb_q; ho_d = ho_q; hc_d = hc_q;
    ta_d = ta_q; tb_d = tb_q; to_d = to_q; tc_d = tc_q;
    if (flush) begin
      cnt_d = 2'd0;
      ha_d = '0; hb_d = '0; ho_d = '0; hc_d = '0;
    end else if (push && pop) begin
      // Only reachable at count 1: the new entry replaces the departing head.
      ha_d = na; hb_d = nb; ho_d = o; hc_d = nc;
    end else if (push) begin
      if (cnt_q == 2'd0) begin
        ha_d = na; hb_d = nb; ho_d = o; hc_d = nc;
      end else begin
        ta_d = na; tb_d = nb; to_d = o; tc_d = nc;
      end
      cnt_d = cnt_q + 2'd1;
    end else if (pop) begin
      if (cnt_q == 2'd2) begin
        ha_d = ta_q; hb_d = tb_q; ho_d = to_q; hc_d = tc_q;
      end else begin
        ha_d = '0; hb_d = '0; ho_d = '0; hc_d = '0;
      end
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= 2'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      ha_q <= '0; hb_q <= '0; ho_q <= '0; hc_q <= '0;
      ta_q <= '0; tb_q <= '0; to_q <= '0; tc_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      in_ready_q  <= (cnt_d != 2'd2);
      out_valid_q <= (cnt_d != 2'd0);
      ha_q <= ha_d; hb_q <= hb_d; ho_q <= ho_d; hc_q <= hc_d;
      ta_q <= ta_d; tb_q <= tb_d; to_q <= to_d; tc_q <= tc_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign a_out     = ha_q;
  assign b_out     = hb_q;
  assign o_out     = ho_q;
  assign cls       = hc_q;

`ifdef FP_DIV_ISSUE_STATS_EN
  logic [15:0] div0_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      div0_q <= 16'd0;
    else if (pop && (hc_q == 3'd2) && (div0_q != 16'hFFFF))
      div0_q <= div0_q + 16'd1;
  end

  assign div0_cnt = div0_q;
`endif

endmodule

// File: tb/tb_fp_div_issue.sv
// Directed scoreboard bench for fp_div_issue; expected entries are queued at push and checked at the head.
module tb_fp_div_issue;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  o;
    logic [2:0]  c;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] a_in, b_in, a_out, b_out;
  logic [1:0]  o, o_out;
  logic [2:0]  cls;
`ifdef FP_DIV_ISSUE_STATS_EN
  logic [15:0] div0_cnt;
`endif

  int     checks = 0;
  int     errors = 0;
  int     cnt = 0;
  entry_t q[$];
  entry_t pend;

  fp_div_issue #(.m(8), .n(23)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .o(o),
    .out_valid(out_valid), .out_ready(out_ready),
    .a_out(a_out), .b_out(b_out), .o_out(o_out), .cls(cls)
`ifdef FP_DIV_ISSUE_STATS_EN
    , .div0_cnt(div0_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       input logic [31:0] ea, input logic [31:0] eb, input logic [2:0] ec);
    in_valid = v; a_in = a; b_in = b; o = op;
    pend = '{a: ea, b: eb, o: op, c: ec};
  endtask

  task automatic idle();
    in_valid = 1'b0; a_in = '0; b_in = '0; o = '0;
  endtask

  // One clock: update the scoreboard from the handshakes, then check the outputs after the edge.
  task automatic tick(input string tag);
    logic pu, po;
    pu = in_valid && in_ready;
    po = out_valid && out_ready;
    if (flush) begin
      q.delete();
      cnt = 0;
    end else begin
      if (po && q.size() > 0) begin
        void'(q.pop_front());
        cnt--;
      end
      if (pu) begin
        q.push_back(pend);
        cnt++;
      end
    end
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 128'(out_valid), 128'(cnt != 0));
    chk({tag, ".in_ready"}, 128'(in_ready), 128'(cnt < 2));
    if (cnt != 0)
      chk({tag, ".head"}, 128'({a_out, b_out, o_out, cls}), 128'(q[0]));
    else
      chk({tag, ".empty_zero"}, 128'({a_out, b_out, o_out, cls}), 128'(0));
  endtask

  task automatic reset_check(input string tag);
    chk({tag, ".in_ready"}, 128'(in_ready), 128'(0));
    chk({tag, ".out_valid"}, 128'(out_valid), 128'(0));
    chk({tag, ".outs"}, 128'({a_out, b_out, o_out, cls}), 128'(0));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    idle();
    #12;
    reset_check("reset");
`ifdef FP_DIV_ISSUE_STATS_EN
    chk("reset.div0", 128'(div0_cnt), 128'(0));
`endif
    @(negedge clk);
    rst = 1'b0;
    tick("rel");

    // Normal operands, 3.0 / 1.0
    out_ready = 1'b1;
    drive(1'b1, 32'h40400000, 32'h3F800000, 2'd1, 32'h40400000, 32'h3F800000, 3'd0);
    tick("norm.push");
    idle();
    tick("norm.pop");

    // Back-to-back pushes against a stalled consumer
    out_ready = 1'b0;
    drive(1'b1, 32'h3F800000, 32'h40000000, 2'd0, 32'h3F800000, 32'h40000000, 3'd0);
    tick("bb.A");
    drive(1'b1, 32'h40800000, 32'h40A00000, 2'd2, 32'h40800000, 32'h40A00000, 3'd0);
    tick("bb.B");
    drive(1'b1, 32'hC0C00000, 32'h40E00000, 2'd3, 32'hC0C00000, 32'h40E00000, 3'd0);
    tick("bb.C_blocked");
    tick("bb.C_blocked2");
    out_ready = 1'b1;
    tick("bb.popA");
    tick("bb.pushC_popB");
    idle();
    tick("bb.popC");

    // Special-case classes and denormal flushing
    drive(1'b1, 32'h7FC00000, 32'h00000000, 2'd1, 32'h7FC00000, 32'h00000000, 3'd4);
    tick("nan_div0");
    drive(1'b1, 32'h80000001, 32'h3F800000, 2'd2, 32'h80000000, 32'h3F800000, 3'd1);
    tick("denorm_a");
    drive(1'b1, 32'h7F800000, 32'h00000000, 2'd0, 32'h7F800000, 32'h00000000, 3'd3);
    tick("inf");
    drive(1'b1, 32'h3F800000, 32'h00000001, 2'd3, 32'h3F800000, 32'h00000000, 3'd2);
    tick("denorm_b");
    drive(1'b1, 32'h00000000, 32'h80000000, 2'd1, 32'h00000000, 32'h80000000, 3'd2);
    tick("zero_zero");
    idle();
    tick("drain");

    // Flush while full with a concurrent push
    out_ready = 1'b0;
    drive(1'b1, 32'h41000000, 32'h41100000, 2'd1, 32'h41000000, 32'h41100000, 3'd0);
    tick("fl.A");
    drive(1'b1, 32'h41200000, 32'h41300000, 2'd2, 32'h41200000, 32'h41300000, 3'd0);
    tick("fl.B");
    flush = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'h41400000, 32'h41500000, 2'd3, 32'h41400000, 32'h41500000, 3'd0);
    tick("fl.flush");
    flush = 1'b0;
    idle();
    tick("fl.after");

    // Reset in the middle of operation
    out_ready = 1'b0;
    drive(1'b1, 32'h41600000, 32'h41700000, 2'd1, 32'h41600000, 32'h41700000, 3'd0);
    tick("mid.A");
    tick("mid.B");
    idle();
    #2;
    rst = 1'b1;
    #1;
    reset_check("mid.rst");
    q.delete();
    cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    tick("mid.rel");

`ifdef FP_DIV_ISSUE_STATS_EN
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h3F800000, 32'h00000000, 2'd0, 32'h3F800000, 32'h00000000, 3'd2);
      tick("st.push");
    end
    idle();
    tick("st.drain");
    chk("stats.three", 128'(div0_cnt), 128'(3));
    #2;
    rst = 1'b1;
    #1;
    chk("stats.rst", 128'(div0_cnt), 128'(0));
    q.delete();
    cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    tick("st.rel");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fp_div_issue.md
FP_DIV_ISSUE -- requirements
Module: fp_div_issue

Interface
REQ-001 The block SHALL have parameter m, default 8, meaning exponent width.
REQ-002 The block SHALL have parameter n, default 23, meaning stored-mantissa width; operand width is m+n+1.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-005 The block SHALL have port flush, input, 1, meaning synchronous discard of all queued entries.
REQ-006 The block SHALL have port in_valid, input, 1, meaning upstream offers an operand pair.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the block accepts the offer this cycle.
REQ-008 The block SHALL have port a_in, input, m+n+1, meaning dividend, IEEE-754 packed.
REQ-009 The block SHALL have port b_in, input, m+n+1, meaning divisor, IEEE-754 packed.
REQ-010 The block SHALL have port o, input, 2, meaning ALU opcode, carried unmodified.
REQ-011 The block SHALL have port out_valid, output, 1, meaning the head entry is presented to the divide stage.
REQ-012 The block SHALL have port out_ready, input, 1, meaning the divide stage consumes the head.
REQ-013 The block SHALL have ports a_out and b_out, output, m+n+1 each, meaning conditioned operands.
REQ-014 The block SHALL have port o_out, output, 2, meaning the opcode of the head entry.
REQ-015 The block SHALL have port cls, output, 3, meaning the special-case class of the head entry.

Function
REQ-016 The block SHALL store entries in a 2-entry FIFO with an occupancy counter, range 0..2.
REQ-017 The block SHALL drive in_ready = (count < 2); there is no same-cycle pass-through when full.
- Push: in_valid && in_ready.
- Pop: out_valid && out_ready.
REQ-018 The block SHALL handle simultaneous push and pop at count 1 by leaving count at 1, with the new entry becoming head on the following cycle.
REQ-019 The block SHALL drive out_valid = (count != 0) and register all head outputs; latency from an accepted push into an empty FIFO to out_valid is 1 cycle.
REQ-020 The block SHALL classify each operand pair at push time, using the first match in this priority order:
- 3'd4: either operand NaN (exp all ones, mantissa != 0).
- 3'd3: either operand infinity.
- 3'd2: b is zero or denormal, i.e. divide-by-zero.
- 3'd1: a is zero or denormal.
- 3'd0: normal.
REQ-021 The block SHALL flush denormal operands to signed zero (mantissa and exponent cleared, sign kept) before storing them.
REQ-022 The block SHALL give flush priority over push and pop in the same cycle: count goes to 0, and a concurrent push is dropped.
REQ-023 The block SHALL hold head outputs stable while out_valid && !out_ready.
REQ-024 The block SHALL drive a_out, b_out, o_out and cls to 0 when count is 0.

Reset
REQ-025 The block SHALL, while rst is high, force count=0, in_ready=0, out_valid=0, and a_out, b_out, o_out, cls to 0.
REQ-026 The block SHALL abandon a reset applied mid-operation and discard queued entries; in_ready returns to 1 on the first clock edge after rst is released.

Configuration
REQ-027 The block SHALL, with macro FP_DIV_ISSUE_STATS_EN defined, add output div0_cnt[15:0], incremented on each pop with cls=3'd2, saturating at 16'hFFFF, and cleared by rst only (not by flush).
REQ-028 The block SHALL, without FP_DIV_ISSUE_STATS_EN, have neither the div0_cnt port nor the counter logic.

Verification
REQ-029 The bench SHALL cover: push a=32'h40400000, b=32'h3F800000 into an empty FIFO, out_ready=1 -> out_valid next cycle, cls=0, and operands unchanged.
REQ-030 The bench SHALL cover: three back-to-back pushes with out_ready=0 -> in_ready drops after the 2nd; the 3rd is accepted only after the first pop, and order is preserved.
REQ-031 The bench SHALL cover: a=32'h7FC00000, b=32'h00000000 -> cls=3'd4 (NaN outranks divide-by-zero).
REQ-032 The bench SHALL cover: a=32'h80000001 (denormal), b=32'h3F800000 -> a_out=32'h80000000 and cls=3'd1.
REQ-033 The bench SHALL cover: count=2 with flush and in_valid both asserted -> count=0 and out_valid=0 next cycle, and the pushed entry is lost.
REQ-034 The bench SHALL cover: with FP_DIV_ISSUE_STATS_EN defined, 3 pops of divisor 32'h00000000 -> div0_cnt=3; then rst -> div0_cnt=0.
